// File: rtl/mac_result_serializer.sv
// Snapshots the 3x3 MAC accumulator array on a capture rising edge and streams
// the valid row_w x col_x window out row-major over a valid/ready interface.
module mac_result_serializer #(
    parameter int unsigned RES_W = 10,
    parameter int unsigned N     = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   capture,
    input  logic [N*N*RES_W-1:0]   mac_res,
    input  logic [1:0]             row_w,
    input  logic [1:0]             col_x,
    output logic [RES_W-1:0]       data_out,
    output logic                   data_valid,
    input  logic                   data_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned NELEM = N * N;
    localparam int unsigned IDX_W = $clog2(NELEM);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]       state_q, state_n;
    logic             capture_q;
    logic             cap_edge;
    logic [RES_W-1:0] buf_q [NELEM];
    logic [RES_W-1:0] buf_n [NELEM];
    logic [1:0]       row_q, row_n, col_q, col_n;
    logic [1:0]       r_q, r_n, c_q, c_n;
    logic [1:0]       r_adv, c_adv;
    logic [IDX_W-1:0] idx_adv;
    logic             last_elem;
    logic [RES_W-1:0] data_out_n;
    logic             valid_n, busy_n, done_n, err_n;

    // Row-major successor of (r,c) inside the latched window
    always_comb begin
        cap_edge  = capture & ~capture_q;
        last_elem = (r_q == row_q - 2'd1) && (c_q == col_q - 2'd1);
        if (c_q == col_q - 2'd1) begin
            c_adv = 2'd0;
            r_adv = r_q + 2'd1;
        end else begin
            c_adv = c_q + 2'd1;
            r_adv = r_q;
        end
        idx_adv = IDX_W'(r_adv) * IDX_W'(N) + IDX_W'(c_adv);
    end

    always_comb begin
        state_n    = state_q;
        buf_n      = buf_q;
        row_n      = row_q;
        col_n      = col_q;
        r_n        = r_q;
        c_n        = c_q;
        data_out_n = data_out;
        valid_n    = data_valid;
        busy_n     = busy;
        done_n     = 1'b0;
        err_n      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cap_edge) begin
                    if (row_w == 2'd0 || col_x == 2'd0) begin
                        err_n = 1'b1;
                    end else begin
                        for (int unsigned k = 0; k < NELEM; k++) begin
                            buf_n[k] = mac_res[k*RES_W +: RES_W];
                        end
                        row_n      = row_w;
                        col_n      = col_x;
                        r_n        = 2'd0;
                        c_n        = 2'd0;
                        data_out_n = mac_res[RES_W-1:0];
                        valid_n    = 1'b1;
                        busy_n     = 1'b1;
                        state_n    = STREAM;
                    end
                end
            end
            STREAM: begin
                // Captures during a stream are deliberately ignored
                if (data_valid && data_ready) begin
                    if (last_elem) begin
                        data_out_n = '0;
                        valid_n    = 1'b0;
                        busy_n     = 1'b0;
                        done_n     = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        r_n        = r_adv;
                        c_n        = c_adv;
                        data_out_n = buf_q[idx_adv];
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // capture_q resets high so a capture already asserted at reset release is not an edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            capture_q  <= 1'b1;
            for (int unsigned k = 0; k < NELEM; k++) begin
                buf_q[k] <= '0;
            end
            row_q      <= 2'd0;
            col_q      <= 2'd0;
            r_q        <= 2'd0;
            c_q        <= 2'd0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_n;
            capture_q  <= capture;
            buf_q      <= buf_n;
            row_q      <= row_n;
            col_q      <= col_n;
            r_q        <= r_n;
            c_q        <= c_n;
            data_out   <= data_out_n;
            data_valid <= valid_n;
            busy       <= busy_n;
            done       <= done_n;
            err        <= err_n;
        end
    end

endmodule

// File: tb/tb_mac_result_serializer.sv
// Scoreboard bench for mac_result_serializer: stimulus pushes the expected
// row-major window, a negedge monitor pops and compares on every transfer.
module tb_mac_result_serializer;

    localparam int unsigned RES_W = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             capture;
    logic [9*RES_W-1:0] mac_res;
    logic [1:0]       row_w, col_x;
    logic [RES_W-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             busy, done, err;

    mac_result_serializer #(.RES_W(RES_W), .N(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (capture),
        .mac_res    (mac_res),
        .row_w      (row_w),
        .col_x      (col_x),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RES_W-1:0] v;
        logic             last;
    } exp_t;

    exp_t             q[$];
    logic [RES_W-1:0] m [3][3];
    int               n_chk = 0;
    int               n_fail = 0;
    int               n_xfer = 0;
    int               ready_mode = 0;
    bit               exp_done_next = 0;
    bit               hold_q = 0;
    logic [RES_W-1:0] hold_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mac();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                mac_res[(i*3+j)*RES_W +: RES_W] = m[i][j];
    endtask

    task automatic rand_mat();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m[i][j] = RES_W'($urandom);
    endtask

    // Reference: the legal window in row-major order, last flagged
    task automatic start_capture(input logic [1:0] r, input logic [1:0] c);
        exp_t e;
        row_w = r;
        col_x = c;
        drive_mac();
        if (r != 2'd0 && c != 2'd0) begin
            for (int i = 0; i < int'(r); i++)
                for (int j = 0; j < int'(c); j++) begin
                    e.v    = m[i][j];
                    e.last = (i == int'(r) - 1) && (j == int'(c) - 1);
                    q.push_back(e);
                end
        end
        capture = 1'b1;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    // Ready patterns: 0 always, 1 repeating 1,0,0, 2 random, 3 never
    initial begin
        int pat;
        pat = 0;
        data_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: data_ready = 1'b1;
                1: begin data_ready = (pat % 3 == 0); pat++; end
                2: data_ready = 1'($urandom);
                default: data_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("done_pulse", 32'(done), 32'(exp_done_next));
            exp_done_next = 0;
            if (hold_q && data_valid)
                chk("hold_stable", 32'(data_out), 32'(hold_data));
            if (data_valid && data_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got data %0d expected no transfer at %0t", data_out, $time);
                end else begin
                    e = q.pop_front();
                    chk("data_out", 32'(data_out), 32'(e.v));
                    n_xfer++;
                    if (e.last) exp_done_next = 1;
                end
            end
            hold_q    = data_valid && !data_ready;
            hold_data = data_out;
        end else begin
            hold_q = 0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int dc, x0;
        logic [1:0] rr, cc;
        rst_n   = 1'b0;
        capture = 1'b1;
        mac_res = '0;
        row_w   = 2'd1;
        col_x   = 2'd1;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m[i][j] = '0;

        // Reset with capture already high: release must not trigger
        repeat (3) tick();
        @(negedge clk);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("noedge_valid", 32'(data_valid), 32'd0);
            chk("noedge_busy", 32'(busy), 32'd0);
            tick();
        end
        capture = 1'b0;
        tick();

        // 1: 2x3 streaming back-to-back, then capture in the done cycle
        ready_mode = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m[i][j] = RES_W'(10 * i + j);
        tick();
        start_capture(2'd2, 2'd3);
        @(negedge clk);
        chk("t1_pre_valid", 32'(data_valid), 32'd0);
        tick();
        capture = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t1_valid_run", 32'(data_valid), 32'd1);
            chk("t1_busy_run", 32'(busy), 32'd1);
            if (k < 5) tick();
        end
        tick();
        rand_mat();
        start_capture(2'd1, 2'd2);
        @(negedge clk);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_done_valid", 32'(data_valid), 32'd0);
        tick();
        capture = 1'b0;
        @(negedge clk);
        chk("t1_recapture_valid", 32'(data_valid), 32'd1);
        wait_done(50, "t1_second_done");
        tick();

        // 2: 3x3 with ready 1,0,0,...
        ready_mode = 1;
        rand_mat();
        x0 = n_xfer;
        tick();
        start_capture(2'd3, 2'd3);
        tick();
        capture = 1'b0;
        wait_done(100, "t2_done");
        chk("t2_xfer_count", 32'(n_xfer - x0), 32'd9);
        ready_mode = 0;
        repeat (2) tick();

        // 3: capture held high with 1x1
        rand_mat();
        start_capture(2'd1, 2'd1);
        dc = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dc++;
            tick();
        end
        chk("t3_one_done", 32'(dc), 32'd1);
        capture = 1'b0;
        tick();
        rand_mat();
        start_capture(2'd1, 2'd1);
        tick();
        capture = 1'b0;
        wait_done(20, "t3_second_run");
        tick();

        // 4: illegal dims
        start_capture(2'd0, 2'd2);
        tick();
        capture = 1'b0;
        @(negedge clk);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_valid", 32'(data_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        tick();
        @(negedge clk);
        chk("t4_err_one_cycle", 32'(err), 32'd0);
        chk("t4_valid_after", 32'(data_valid), 32'd0);
        tick();

        // 5: mid-stream capture/mac change, then reset
        ready_mode = 3;
        tick();
        rand_mat();
        start_capture(2'd3, 2'd3);
        tick();
        capture = 1'b0;
        tick();
        rand_mat();
        drive_mac();
        capture = 1'b1;
        tick();
        capture = 1'b0;
        @(negedge clk);
        chk("t5_no_err", 32'(err), 32'd0);
        ready_mode = 0;
        repeat (4) tick();
        ready_mode = 3;
        repeat (2) tick();
        @(negedge clk);
        chk("t5_busy_before_rst", 32'(busy), 32'd1);
        tick();
        rst_n = 1'b0;
        q.delete();
        exp_done_next = 0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_rst_valid", 32'(data_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_data", 32'(data_out), 32'd0);
        repeat (3) tick();
        ready_mode = 0;
        tick();

        // Random runs
        for (int n = 0; n < 40; n++) begin
            ready_mode = int'($urandom_range(0, 2));
            rr = 2'($urandom_range(0, 3));
            cc = 2'($urandom_range(0, 3));
            rand_mat();
            tick();
            start_capture(rr, cc);
            tick();
            capture = 1'b0;
            @(negedge clk);
            chk("rnd_err", 32'(err), 32'((rr == 2'd0) || (cc == 2'd0)));
            if (rr == 2'd0 || cc == 2'd0) begin
                chk("rnd_err_valid", 32'(data_valid), 32'd0);
            end else begin
                chk("rnd_busy", 32'(busy), 32'd1);
                wait_done(300, "rnd_done");
            end
            tick();
            if (($urandom & 1) != 0) begin
                row_w = 2'($urandom);
                col_x = 2'($urandom);
            end
        end
        repeat (3) tick();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
